// File: rtl/riscv151_mem_pkg.sv
// Shared definitions for the Riscv151 data-memory subsystem: widths and port ids.
package riscv151_mem_pkg;

    localparam int DMEM_ADDR_W = 14;
    localparam int WORD_W      = 32;
    localparam int BE_W        = 4;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_id_e;

endpackage

// File: rtl/rr_burst_picker.sv
// Burst-limited round-robin picker: tracks the last owner and how many grants
// in a row it has taken, and chooses which of two requesters wins this cycle.
module rr_burst_picker
    import riscv151_mem_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     req0,
    input  logic     req1,
    output logic     grant,
    output port_id_e grant_port
);

    localparam logic [3:0] BURST_CNT = 4'(BURST);

    port_id_e   owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;

    // A lone requester always wins; under contention the owner keeps the bus until its burst is spent.
    always_comb begin
        grant      = req0 | req1;
        grant_port = PORT_CPU;
        if (req0 && req1) begin
            if (cnt_q < BURST_CNT) begin
                grant_port = owner_q;
            end else begin
                grant_port = (owner_q == PORT_CPU) ? PORT_LDR : PORT_CPU;
            end
        end else if (req1) begin
            grant_port = PORT_LDR;
        end
    end

    // Count consecutive grants to the owner (saturating); a grant to the other port restarts the burst.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (grant) begin
            if (grant_port == owner_q) begin
                if (cnt_q < BURST_CNT) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                owner_d = grant_port;
                cnt_d   = 4'd1;
            end
        end
    end

    // Owner/count registers; reset hands first contended grant to the CPU port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= PORT_CPU;
            cnt_q   <= 4'd0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU port (0) and
// loader/DMA port (1). Grants one access per cycle and steers the registered
// read data back to whichever port issued the access.
module dmem_arbiter
    import riscv151_mem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [BE_W-1:0]   p0_we,
    input  logic [WORD_W-1:0] p0_wdata,
    output logic              p0_resp_valid,
    output logic [WORD_W-1:0] p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [BE_W-1:0]   p1_we,
    input  logic [WORD_W-1:0] p1_wdata,
    output logic              p1_resp_valid,
    output logic [WORD_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    logic     grant;
    port_id_e grant_port;

    logic     rsp_vld_q, rsp_vld_d;
    port_id_e rsp_port_q, rsp_port_d;
    logic     rsp_rd_q, rsp_rd_d;

    rr_burst_picker #(
        .BURST(BURST)
    ) u_picker (
        .clk       (clk),
        .rst       (rst),
        .req0      (p0_valid),
        .req1      (p1_valid),
        .grant     (grant),
        .grant_port(grant_port)
    );

    // Accept only the granted port and drive the memory from it; memory bus is zero when idle.
    always_comb begin
        p0_ready  = 1'b0;
        p1_ready  = 1'b0;
        mem_en    = grant;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant) begin
            if (grant_port == PORT_CPU) begin
                p0_ready  = 1'b1;
                mem_we    = p0_we;
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
            end else begin
                p1_ready  = 1'b1;
                mem_we    = p1_we;
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
            end
        end
    end

    // Remember who issued this cycle's access and whether it was a read, to match the memory's 1-cycle latency.
    always_comb begin
        rsp_vld_d  = grant;
        rsp_port_d = grant_port;
        rsp_rd_d   = grant && (mem_we == '0);
    end

    // Response pipeline register; reset drops any access still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= PORT_CPU;
            rsp_rd_q   <= 1'b0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    // Steer the response to its port; read data only passes for reads, writes get a zero-data ack.
    always_comb begin
        p0_resp_valid = rsp_vld_q && (rsp_port_q == PORT_CPU);
        p1_resp_valid = rsp_vld_q && (rsp_port_q == PORT_LDR);
        p0_rdata      = (p0_resp_valid && rsp_rd_q) ? mem_rdata : '0;
        p1_rdata      = (p1_resp_valid && rsp_rd_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed per-cycle vectors push expected
// responses, a negedge monitor pops and checks them against the DUT.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic        p0_ready, p1_ready;
    logic [13:0] p0_addr = 14'd0, p1_addr = 14'd0;
    logic [3:0]  p0_we = 4'h0, p1_we = 4'h0;
    logic [31:0] p0_wdata = 32'h0, p1_wdata = 32'h0;
    logic        p0_resp_valid, p1_resp_valid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] mem [0:16383];

    dmem_arbiter #(
        .ADDR_W(14),
        .BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_addr      (p0_addr),
        .p0_we        (p0_we),
        .p0_wdata     (p0_wdata),
        .p0_resp_valid(p0_resp_valid),
        .p0_rdata     (p0_rdata),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_addr      (p1_addr),
        .p1_we        (p1_we),
        .p1_wdata     (p1_wdata),
        .p1_resp_valid(p1_resp_valid),
        .p1_rdata     (p1_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected responses.
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory model with registered read and byte-enabled writes; reset reloads known contents.
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 32'h11111111;
            mem[1] <= 32'h22222222;
            mem[2] <= 32'h12345678;
            mem[5] <= 32'h00000000;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    // Drive one cycle of requests, check ready/mem_en against the expected grant, queue expected responses.
    task automatic applyStimulus(
        input logic v0, input logic [13:0] a0, input logic [3:0] we0, input logic [31:0] wd0,
        input logic v1, input logic [13:0] a1, input logic [3:0] we1, input logic [31:0] wd1,
        input logic er0, input logic er1, input logic [31:0] ex0, input logic [31:0] ex1);
        exp_t e;
        @(posedge clk);
        #1;
        p0_valid = v0; p0_addr = a0; p0_we = we0; p0_wdata = wd0;
        p1_valid = v1; p1_addr = a1; p1_we = we1; p1_wdata = wd1;
        #2;
        checkOutput("p0_ready", 32'(p0_ready), 32'(er0));
        checkOutput("p1_ready", 32'(p1_ready), 32'(er1));
        checkOutput("mem_en", 32'(mem_en), 32'(er0 | er1));
        if (er0) begin
            e.data = ex0; e.due = cyc + 1;
            q0.push_back(e);
        end
        if (er1) begin
            e.data = ex1; e.due = cyc + 1;
            q1.push_back(e);
        end
    endtask

    // Response monitor: each port must respond exactly on its due cycle with the queued data.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        while (q0.size() > 0 && q0[0].due < cyc) void'(q0.pop_front());
        exp_v = (q0.size() > 0) && (q0[0].due == cyc);
        checkOutput("p0_resp_valid", 32'(p0_resp_valid), 32'(exp_v));
        if (p0_resp_valid && exp_v) begin
            e = q0.pop_front();
            checkOutput("p0_rdata", p0_rdata, e.data);
        end
        while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
        exp_v = (q1.size() > 0) && (q1[0].due == cyc);
        checkOutput("p1_resp_valid", 32'(p1_resp_valid), 32'(exp_v));
        if (p1_resp_valid && exp_v) begin
            e = q1.pop_front();
            checkOutput("p1_rdata", p1_rdata, e.data);
        end
    end

    logic [8:0] g_seq;

    initial begin
        g_seq = 9'b0_1111_0000;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_p0_rdata", p0_rdata, 32'd0);
        checkOutput("rst_p1_rdata", p1_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention straight after reset: 0,0,0,0,1,1,1,1,0
        $display("[TB] burst contention after reset");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0,
                          ~g_seq[i], g_seq[i], 32'h11111111, 32'h22222222);
        end

        // Port 0 alone: write then read back
        $display("[TB] port 0 write/read");
        applyStimulus(1'b1, 14'd5, 4'hF, 32'hDEADBEEF, 1'b0, 14'd0, 4'h0, 32'h0,
                      1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 14'd5, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0,
                      1'b1, 1'b0, 32'hDEADBEEF, 32'h0);

        // Byte-enable write from port 1, read back through port 0
        $display("[TB] byte enables");
        applyStimulus(1'b0, 14'd0, 4'h0, 32'h0, 1'b1, 14'd2, 4'h1, 32'h000000AB,
                      1'b0, 1'b1, 32'h0, 32'h0);
        applyStimulus(1'b1, 14'd2, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0,
                      1'b1, 1'b0, 32'h123456AB, 32'h0);

        // Idle keeps owner/cnt: port 0 at cnt 2, five idle cycles, then it gets exactly two more
        $display("[TB] idle hold");
        applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0,
                      1'b1, 1'b0, 32'h11111111, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 14'd0, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0,
                          1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
            checkOutput("idle_mem_addr", 32'(mem_addr), 32'd0);
        end
        applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0,
                      1'b1, 1'b0, 32'h11111111, 32'h22222222);
        applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0,
                      1'b1, 1'b0, 32'h11111111, 32'h22222222);
        applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0,
                      1'b0, 1'b1, 32'h11111111, 32'h22222222);

        // Handoff: port 1 streams 10 reads, port 0 joins at cycle 3 and wins once port 1's burst is spent
        $display("[TB] contention handoff");
        for (int i = 0; i < 11; i++) begin
            if (i == 3) begin
                applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0,
                              1'b1, 1'b0, 32'h11111111, 32'h22222222);
            end else begin
                applyStimulus(1'b0, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0,
                              1'b0, 1'b1, 32'h0, 32'h22222222);
            end
        end

        // Reset the cycle after a port 0 read accept: the response is dropped and the burst restarts
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0,
                      1'b1, 1'b0, 32'h11111111, 32'h0);
        @(posedge clk);
        #1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #2;
        checkOutput("rst_mid_p0_resp_valid", 32'(p0_resp_valid), 32'd0);
        checkOutput("rst_mid_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #3;
        checkOutput("rst_mid_p0_resp_valid2", 32'(p0_resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        g_seq = 9'b0_0001_0000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0,
                          ~g_seq[i], g_seq[i], 32'h11111111, 32'h22222222);
        end

        // Drain and make sure nothing was lost
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 14'd0, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0,
                          1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(posedge clk);
        #3;
        checkOutput("q0_drain", 32'(q0.size()), 32'd0);
        checkOutput("q1_drain", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the Riscv151 single-port data memory between the CPU load/store port (port 0) and the UART program-loader / MMIO DMA port (port 1). Each cycle it grants at most one request and drives the memory. It routes the 1-cycle-latency read data back to the granted port. Arbitration is burst-limited round-robin, so neither port can starve the other.

## Interface
- ADDR_W, 14: word-address width (16K words).
- BURST, 4: maximum consecutive grants to one port while the other waits; 1..15.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_valid / p1_valid  in  1  request present.
- p0_ready / p1_ready  out  1  request accepted this cycle (valid && ready = accept).
- p0_addr / p1_addr  in  ADDR_W  word address.
- p0_we / p1_we  in  4  byte write enables; 0 = read.
- p0_wdata / p1_wdata  in  32  write data.
- p0_resp_valid / p1_resp_valid  out  1  response (read data or write ack) for that port.
- p0_rdata / p1_rdata  out  32  read data; valid only with resp_valid on a read.
- mem_en  out  1  memory access this cycle.
- mem_we  out  4  byte enables to memory.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, registered in memory, one cycle after mem_en.

## Operation
- State:
  - owner: 1 bit, last granted port.
  - cnt: 4 bits, consecutive grants to owner.
  - rsp_port, rsp_vld, rsp_rd: response pipeline register.
- Grant rule (combinational):
  - Only one port valid: grant it.
  - Both valid, owner's cnt < BURST: grant owner.
  - Both valid, cnt == BURST: grant the other port.
  - Neither valid: no grant, mem_en = 0.
- On grant to port g:
  - If g == owner: cnt <= cnt+1, saturating at BURST.
  - Else: owner <= g, cnt <= 1.
  - No grant: owner and cnt hold.
- ready is asserted only for the granted port. The ungranted port sees ready = 0 and must hold its request stable.
- mem_en = grant. mem_addr, mem_we and mem_wdata mux from the granted port; they are 0 when idle.
- Response pipeline:
  - rsp_vld <= grant, rsp_port <= g, rsp_rd <= (we == 0).
  - p[g]_resp_valid = rsp_vld && rsp_port == g.
  - p[g]_rdata = mem_rdata when rsp_rd, else 0.
- Back-to-back accesses to the same port are fully pipelined: one accept per cycle.
- The arbiter does no write-to-read forwarding. Memory is single-port, so ordering equals grant order.

## Timing
- Accept: same cycle as valid (combinational ready, no bubble).
- Read latency: resp_valid and rdata appear exactly 1 cycle after accept. Write ack has the same latency.
- Reset values:
  - owner = 0, cnt = 0, rsp_vld = 0.
  - All resp_valid = 0, all rdata = 0.
  - mem_en = 0 (given valids low).
- Reset after reset, if both ports are valid: port 0 wins the first grant.
- Reset mid-operation: an in-flight response is discarded. resp_valid is 0 from reset assertion until the first post-reset grant + 1.
- Idle cycles do not reset cnt. A port that stops requesting loses priority only through the "other port granted" path.
- BURST == 1 degenerates to strict alternation under contention.
- Port 0 must not see a combinational path from p1_ready to p0_valid (no loops).

## Structure
- Shared package riscv151_mem_pkg holds:
  - constants: DMEM_ADDR_W = 14, WORD_W = 32, BE_W = 4;
  - port-id enum: PORT_CPU = 0, PORT_LDR = 1.
- One natural sub-module: rr_burst_picker (owner/cnt state and grant logic). The datapath mux and response pipeline stay in dmem_arbiter.

## Test plan
- Port 0 alone: write 0xDEADBEEF at addr 5 with we = 0xF, then read addr 5. Required:
  - p0_ready = 1 both cycles;
  - p0_resp_valid one cycle after each accept;
  - read returns 0xDEADBEEF;
  - p1_resp_valid stays 0.
- Both valid continuously, BURST = 4, starting right after reset. Required grant sequence: 0,0,0,0,1,1,1,1,0…
  - Verify each port's responses carry that port's data: port 0 reads addr 0 = 0x11111111; port 1 reads addr 1 = 0x22222222.
- Byte enables: port 1 writes 0x000000AB at addr 2 with we = 0x1 over prior 0x12345678. A port 0 read of addr 2 returns 0x123456AB.
- Contention handoff: port 1 streams 10 reads, and port 0 raises valid at cycle 3. Required:
  - port 0 granted no later than cycle 3 + BURST;
  - port 0's response arrives 1 cycle after its grant;
  - port 1 sees no lost or duplicated response.
- Reset mid-operation: assert rst the cycle after a port 0 read accept. Required:
  - p0_resp_valid = 0 during reset;
  - owner = 0, cnt = 0;
  - the first post-reset contended grant goes to port 0.
- Idle: both valid = 0 for 5 cycles. Required:
  - mem_en = 0, mem_we = 0;
  - no resp_valid;
  - owner and cnt unchanged.
